// File: rtl/scr_readout_mac.sv
// Linear readout for the SCR reservoir: y = sat(sum W[k]*x[k]) via one serially reused MAC.
// Optional macro READOUT_BIAS_EN adds a bias register at weight address N.
module scr_readout_mac #(
  parameter int N     = 50,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW*N-1:0] x_flat,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  output logic            busy,
  output logic [DW-1:0]   y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            y_sat
);

  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_e;

  localparam logic [AW-1:0] LAST_K    = AW'(N - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 << (DW - 1)));

  state_e                   state_q;
  logic signed [DW-1:0]     w_q  [N];
  logic signed [DW-1:0]     xs_q [N];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_init;
  logic [AW-1:0]            k_q;
  logic signed [2*DW-1:0]   prod;
  logic [DW-1:0]            y_q;
  logic                     y_valid_q;
  logic                     y_sat_q;
  logic [DW:0]              sat_res;
  logic                     w_hit;

  // Floor the Q.30 accumulator back to Q1.15 and clip; MSB of the result flags clipping.
  function automatic logic [DW:0] sat_q15(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> (DW - 1);
    if (s > Y_MAX)      sat_q15 = {1'b1, Y_MAX[DW-1:0]};
    else if (s < Y_MIN) sat_q15 = {1'b1, Y_MIN[DW-1:0]};
    else                sat_q15 = {1'b0, s[DW-1:0]};
  endfunction

  assign w_hit   = w_we && (state_q == IDLE);
  assign x_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_sat   = y_sat_q;

  assign prod    = w_q[k_q] * xs_q[k_q];
  assign acc_d   = acc_q + ACC_W'(prod);
  assign sat_res = sat_q15(acc_q);

`ifdef READOUT_BIAS_EN
  logic signed [DW-1:0] bias_q;
  logic signed [DW-1:0] bias_eff;

  // A bias write on the accepting edge must already seed this computation.
  assign bias_eff = (w_hit && (w_addr == BIAS_ADDR)) ? signed'(w_data) : bias_q;
  assign acc_init = ACC_W'(bias_eff) <<< (DW - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bias_q <= '0;
    else if (w_hit && (w_addr == BIAS_ADDR))
      bias_q <= w_data;
  end
`else
  assign acc_init = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      k_q       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sat_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_q[i]  <= '0;
        xs_q[i] <= '0;
      end
    end else begin
      if (w_hit && (w_addr < BIAS_ADDR))
        w_q[w_addr] <= w_data;

      case (state_q)
        IDLE: begin
          if (x_valid) begin
            for (int i = 0; i < N; i++)
              xs_q[i] <= x_flat[DW*i +: DW];
            acc_q   <= acc_init;
            k_q     <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == LAST_K)
            state_q <= SAT;
        end
        SAT: begin
          y_q       <= sat_res[DW-1:0];
          y_sat_q   <= sat_res[DW];
          y_valid_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (y_ready) begin
            y_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scr_readout_mac.sv
// Directed + randomized bench for scr_readout_mac against an arithmetic reference model.
module tb_scr_readout_mac;
  localparam int N = 50;
  localparam int DW = 16;
  localparam int AW = 6;
`ifdef READOUT_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW*N-1:0] x_flat = '0;
  logic            x_valid = 1'b0;
  logic            x_ready;
  logic            w_we = 1'b0;
  logic [AW-1:0]   w_addr = '0;
  logic [DW-1:0]   w_data = '0;
  logic            busy;
  logic [DW-1:0]   y;
  logic            y_valid;
  logic            y_ready = 1'b0;
  logic            y_sat;

  scr_readout_mac #(.N(N), .DW(DW), .ACC_W(40), .AW(AW)) dut (
    .clk(clk), .reset(reset), .x_flat(x_flat), .x_valid(x_valid), .x_ready(x_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_sat(y_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  shortint wm [N];
  shortint xv [N];
  int bm = 0;
  logic [DW-1:0] ey;
  logic es;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product plus bias, floored to Q1.15 and clipped.
  task automatic model();
    longint s;
    longint q;
    s = longint'(bm) * 32768;
    for (int k = 0; k < N; k++)
      s += longint'(wm[k]) * longint'(xv[k]);
    q = s >>> 15;
    if (q > 32767) begin ey = 16'h7FFF; es = 1'b1; end
    else if (q < -32768) begin ey = 16'h8000; es = 1'b1; end
    else begin ey = 16'(q); es = 1'b0; end
  endtask

  task automatic model_write(input int addr, input logic [15:0] data);
    if (addr < N) wm[addr] = shortint'(data);
    else if (addr == N && BIAS_EN) bm = int'(shortint'(data));
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    @(negedge clk);
    w_we = 1'b1; w_addr = AW'(addr); w_data = data;
    @(negedge clk);
    w_we = 1'b0;
    model_write(addr, data);
  endtask

  task automatic tick();
    @(negedge clk);
    lat++;
  endtask

  task automatic start(input bit we, input int addr, input logic [15:0] data);
    @(negedge clk);
    for (int k = 0; k < N; k++) x_flat[DW*k +: DW] = xv[k];
    x_valid = 1'b1;
    w_we = we; w_addr = AW'(addr); w_data = data;
    if (we) model_write(addr, data);
    model();
    @(negedge clk);
    lat = 0;
    x_valid = 1'b0;
    w_we = 1'b0;
    for (int k = 0; k < N; k++) x_flat[DW*k +: DW] = DW'($urandom);
    check("accepted_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish(input int hold);
    while (!y_valid && lat < 200) tick();
    check("latency", lat, N + 1);
    check("y", {16'd0, y}, {16'd0, ey});
    check("y_sat", {31'd0, y_sat}, {31'd0, es});
    for (int h = 0; h < hold; h++) begin
      x_valid = 1'b1;
      @(negedge clk);
      check("hold_y", {16'd0, y}, {16'd0, ey});
      check("hold_valid", {31'd0, y_valid}, 32'd1);
      check("hold_sat", {31'd0, y_sat}, {31'd0, es});
      check("hold_xready", {31'd0, x_ready}, 32'd0);
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    check("idle_after_ack", {30'd0, busy, y_valid}, 32'd0);
    check("y_held", {16'd0, y}, {16'd0, ey});
  endtask

  int vcount;

  initial begin
    for (int k = 0; k < N; k++) begin wm[k] = 0; xv[k] = 0; end
    repeat (3) @(negedge clk);
    check("rst_y", {16'd0, y}, 32'd0);
    check("rst_valid", {31'd0, y_valid}, 32'd0);
    check("rst_sat", {31'd0, y_sat}, 32'd0);
    check("rst_xready", {31'd0, x_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // zero weights, arbitrary x
    for (int k = 0; k < N; k++) xv[k] = shortint'($urandom);
    start(1'b0, 0, 16'h0);
    finish(0);
    check("zero_w_y", {16'd0, y}, 32'd0);

    // single half weight
    wr(0, 16'h4000);
    for (int k = 0; k < N; k++) xv[k] = shortint'($urandom);
    xv[0] = 16'sh7FFF;
    start(1'b0, 0, 16'h0);
    finish(0);
    check("w0_half_y", {16'd0, y}, 32'h3FFF);

    // positive saturation with backpressure
    for (int k = 0; k < N; k++) begin wr(k, 16'h7FFF); xv[k] = 16'sh7FFF; end
    start(1'b0, 0, 16'h0);
    finish(10);
    check("pos_sat", {15'd0, y_sat, y}, 32'h17FFF);

    // negative saturation
    for (int k = 0; k < N; k++) begin wr(k, 16'h8000); xv[k] = 16'sh4000; end
    start(1'b0, 0, 16'h0);
    finish(2);
    check("neg_sat", {15'd0, y_sat, y}, 32'h18000);

    // randomized weights/states, some with a write on the accepting edge
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < N; k++) begin
        if (it < 3) wr(k, 16'($urandom_range(0, 4095) - 2048));
        else        wr(k, 16'($urandom));
        xv[k] = shortint'($urandom);
      end
      start(it[0], $urandom_range(0, N - 1), 16'($urandom));
      finish(it % 3);
    end

    // write during MAC is ignored for this and the next result
    wr(0, 16'h0000);
    xv[0] = 16'sh7FFF;
    start(1'b0, 0, 16'h0);
    repeat (5) tick();
    w_we = 1'b1; w_addr = '0; w_data = 16'h7FFF;
    tick();
    w_we = 1'b0;
    finish(0);
    start(1'b0, 0, 16'h0);
    finish(0);

    // out-of-range address ignored
    wr(63, 16'h7FFF);
    start(1'b0, 0, 16'h0);
    finish(0);

    // reset at k == 20 aborts and clears weights
    start(1'b0, 0, 16'h0);
    repeat (20) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_y", {16'd0, y}, 32'd0);
    check("abort_valid", {31'd0, y_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) wm[k] = 0;
    bm = 0;
    vcount = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (y_valid) vcount++;
    end
    check("no_valid_after_abort", vcount, 0);
    for (int k = 0; k < N; k++) xv[k] = shortint'($urandom);
    start(1'b0, 0, 16'h0);
    finish(0);
    check("weights_cleared_y", {16'd0, y}, 32'd0);

    // bias address
    wr(N, 16'h2000);
    start(1'b0, 0, 16'h0);
    finish(0);
    check("bias_y", {16'd0, y}, BIAS_EN ? 32'h2000 : 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
